// File: rtl/maze_pkg.sv
// Shared constants, cell encodings and FSM state type for the maze scan controller.
package maze_pkg;

    localparam int unsigned CELL_W = 10;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned WALL_CNT_W = 11;

    // Special cell words
    localparam logic [CELL_W-1:0] CELL_START = 10'h1FF;
    localparam logic [CELL_W-1:0] CELL_GOAL  = 10'h000;

    // Wall is a single flag bit; marker is a two-bit field that only counts on non-wall cells
    localparam int unsigned WALL_BIT     = 9;
    localparam int unsigned MARKER_HI    = 8;
    localparam int unsigned MARKER_LO    = 7;
    localparam logic [1:0]  MARKER_CODE  = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StScan  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/maze_cell_decode.sv
// Combinational classification of one map cell word into start/goal/wall/marker flags.
module maze_cell_decode
    import maze_pkg::*;
(
    input  logic [CELL_W-1:0] i_cell,
    output logic              o_start,
    output logic              o_goal,
    output logic              o_wall,
    output logic              o_marker
);

    // Start and goal are exact-match codes; the start code has the wall bit clear
    always_comb begin
        o_start  = (i_cell == CELL_START);
        o_goal   = (i_cell == CELL_GOAL);
        o_wall   = i_cell[WALL_BIT];
        o_marker = (i_cell[MARKER_HI:MARKER_LO] == MARKER_CODE) && !i_cell[WALL_BIT];
    end

endmodule

// File: rtl/maze_scan_ctrl.sv
// Sequentially reads every map cell, forwards each word to the classifier and
// records the first start/goal positions, duplicate errors and the wall count.
module maze_scan_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned MAP_CELLS = 1024
) (
    input  logic                  p_reset,
    input  logic                  m_clock,
    input  logic                  scan_req,
    input  logic                  scan_abort,
    output logic                  mem_rd,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [CELL_W-1:0]     mem_rdata,
    output logic                  blk_in_do,
    output logic [CELL_W-1:0]     blk_map,
    output logic [ADDR_W-1:0]     blk_now,
    output logic                  scan_busy,
    output logic                  scan_done,
    output logic [ADDR_W-1:0]     start_pos,
    output logic [ADDR_W-1:0]     goal_pos,
    output logic                  start_found,
    output logic                  goal_found,
    output logic                  err_dup,
    output logic [WALL_CNT_W-1:0] wall_count
);

    localparam logic [ADDR_W-1:0]     LastAddr = ADDR_W'(MAP_CELLS - 1);
    localparam logic [WALL_CNT_W-1:0] WallMax  = '1;

    scan_state_e             r_state;
    scan_state_e             w_state_d;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_rd_vld;
    logic [ADDR_W-1:0]       r_rd_addr;
    logic [ADDR_W-1:0]       r_start_pos;
    logic [ADDR_W-1:0]       r_goal_pos;
    logic                    r_start_found;
    logic                    r_goal_found;
    logic                    r_err_dup;
    logic [WALL_CNT_W-1:0]   r_wall_count;

    logic                    w_accept;
    logic                    w_abort;
    logic                    w_in_scan;
    logic                    w_is_start;
    logic                    w_is_goal;
    logic                    w_is_wall;
    logic                    w_unused_marker;

    assign w_in_scan = (r_state == StScan);
    // Abort beats a simultaneous request in IDLE, so a request is only accepted without abort
    assign w_accept  = (r_state == StIdle) && scan_req && !scan_abort;
    assign w_abort   = scan_abort && (r_state == StScan || r_state == StDrain);

    maze_cell_decode u_cell_decode (
        .i_cell   (mem_rdata),
        .o_start  (w_is_start),
        .o_goal   (w_is_goal),
        .o_wall   (w_is_wall),
        .o_marker (w_unused_marker)
    );

    // State register
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // Next-state logic
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_d = StScan;
            StScan: begin
                if (scan_abort)              w_state_d = StIdle;
                else if (r_addr == LastAddr) w_state_d = StDrain;
            end
            StDrain: w_state_d = scan_abort ? StIdle : StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Address counter; holds at the last address so it never runs past the map
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_addr <= '0;
        end else if (w_accept) begin
            r_addr <= '0;
        end else if (w_in_scan && (r_addr != LastAddr)) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Read-data qualifier pipeline; an abort drops the read still in flight
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_rd_vld  <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            r_rd_vld  <= w_in_scan && !scan_abort;
            r_rd_addr <= (w_in_scan && !scan_abort) ? r_addr : '0;
        end
    end

    // Result registers: cleared on scan start, flags cleared on abort, else updated per cell
    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            r_start_pos   <= '0;
            r_goal_pos    <= '0;
            r_start_found <= 1'b0;
            r_goal_found  <= 1'b0;
            r_err_dup     <= 1'b0;
            r_wall_count  <= '0;
        end else if (w_accept) begin
            r_start_pos   <= '0;
            r_goal_pos    <= '0;
            r_start_found <= 1'b0;
            r_goal_found  <= 1'b0;
            r_err_dup     <= 1'b0;
            r_wall_count  <= '0;
        end else if (w_abort) begin
            r_start_found <= 1'b0;
            r_goal_found  <= 1'b0;
            r_err_dup     <= 1'b0;
        end else if (r_rd_vld) begin
            if (w_is_start) begin
                if (r_start_found) begin
                    r_err_dup <= 1'b1;
                end else begin
                    r_start_pos   <= r_rd_addr;
                    r_start_found <= 1'b1;
                end
            end
            if (w_is_goal) begin
                if (r_goal_found) begin
                    r_err_dup <= 1'b1;
                end else begin
                    r_goal_pos   <= r_rd_addr;
                    r_goal_found <= 1'b1;
                end
            end
            if (w_is_wall && (r_wall_count != WallMax)) begin
                r_wall_count <= r_wall_count + 1'b1;
            end
        end
    end

    // Output drive; classifier sees zeros whenever the qualifier is low
    always_comb begin
        mem_rd      = w_in_scan;
        mem_addr    = w_in_scan ? r_addr : '0;
        blk_in_do   = r_rd_vld;
        blk_map     = r_rd_vld ? mem_rdata : '0;
        blk_now     = r_rd_vld ? r_rd_addr : '0;
        scan_busy   = (r_state == StScan) || (r_state == StDrain);
        scan_done   = (r_state == StDone);
        start_pos   = r_start_pos;
        goal_pos    = r_goal_pos;
        start_found = r_start_found;
        goal_found  = r_goal_found;
        err_dup     = r_err_dup;
        wall_count  = r_wall_count;
    end

endmodule

// File: tb/tb_maze_scan_ctrl.sv
// Directed bench for maze_scan_ctrl with a 16-cell map and a one-cycle-latency RAM model.
module tb_maze_scan_ctrl;

    localparam int unsigned NCELLS = 16;

    logic        p_reset;
    logic        m_clock;
    logic        scan_req;
    logic        scan_abort;
    logic        mem_rd;
    logic [9:0]  mem_addr;
    logic [9:0]  mem_rdata;
    logic        blk_in_do;
    logic [9:0]  blk_map;
    logic [9:0]  blk_now;
    logic        scan_busy;
    logic        scan_done;
    logic [9:0]  start_pos;
    logic [9:0]  goal_pos;
    logic        start_found;
    logic        goal_found;
    logic        err_dup;
    logic [10:0] wall_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] mem [1024];
    logic [9:0] prev_addr;
    logic       mon_en = 1'b0;

    maze_scan_ctrl #(.MAP_CELLS(NCELLS)) dut (
        .p_reset     (p_reset),
        .m_clock     (m_clock),
        .scan_req    (scan_req),
        .scan_abort  (scan_abort),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .blk_in_do   (blk_in_do),
        .blk_map     (blk_map),
        .blk_now     (blk_now),
        .scan_busy   (scan_busy),
        .scan_done   (scan_done),
        .start_pos   (start_pos),
        .goal_pos    (goal_pos),
        .start_found (start_found),
        .goal_found  (goal_found),
        .err_dup     (err_dup),
        .wall_count  (wall_count)
    );

    initial m_clock = 1'b0;
    always #5 m_clock = ~m_clock;

    // Map RAM model: data valid the cycle after the read strobe
    always @(posedge m_clock) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        prev_addr <= mem_addr;
    end

    // Per-cycle classifier interface check
    always @(negedge m_clock) begin
        if (mon_en && p_reset) begin
            n_checks++;
            if (blk_in_do) begin
                if (blk_now !== prev_addr || blk_map !== mem_rdata) begin
                    n_fail++;
                    $display("FAIL blk_iface: blk_now=%0h blk_map=%0h, required %0h / %0h",
                             blk_now, blk_map, prev_addr, mem_rdata);
                end
            end else if (blk_now !== 10'h0 || blk_map !== 10'h0) begin
                n_fail++;
                $display("FAIL blk_idle_zero: blk_now=%0h blk_map=%0h, required 0 / 0",
                         blk_now, blk_map);
            end
        end
    end

    task automatic load_mem(input logic [9:0] fill);
        for (int i = 0; i < 1024; i++) mem[i] = fill;
    endtask

    // Pulse scan_req for the acceptance edge and wait for scan_done (bounded)
    task automatic run_scan(output int cyc, output bit seen);
        @(negedge m_clock);
        scan_req = 1'b1;
        @(posedge m_clock);
        #1 scan_req = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge m_clock);
            if (scan_done) begin
                cyc  = i;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        p_reset = 1'b0;
        repeat (3) @(negedge m_clock);
        n_checks++;
        if ({mem_rd, mem_addr, blk_in_do, scan_busy, scan_done, start_pos, goal_pos,
             start_found, goal_found, err_dup, wall_count} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: some output nonzero (busy=%b done=%b rd=%b wc=%0d)",
                     scan_busy, scan_done, mem_rd, wall_count);
        end
        p_reset = 1'b1;
        @(negedge m_clock);
        mon_en = 1'b1;
        n_checks++;
        if (scan_busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b rd=%b, required 0 0", scan_busy, mem_rd);
        end
    endtask

    task automatic test_basic;
        int cyc;
        bit seen;
        load_mem(10'h001);
        mem[3] = 10'h1FF;
        mem[9] = 10'h000;
        run_scan(cyc, seen);
        n_checks++;
        if (!seen || cyc != 18) begin
            n_fail++;
            $display("FAIL basic_latency: seen=%b cycle=%0d, required 1 18", seen, cyc);
        end
        n_checks++;
        if (start_pos !== 10'd3 || start_found !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start: pos=%0d found=%b, required 3 1", start_pos, start_found);
        end
        n_checks++;
        if (goal_pos !== 10'd9 || goal_found !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_goal: pos=%0d found=%b, required 9 1", goal_pos, goal_found);
        end
        n_checks++;
        if (err_dup !== 1'b0 || wall_count !== 11'd0) begin
            n_fail++;
            $display("FAIL basic_dup_wall: dup=%b wc=%0d, required 0 0", err_dup, wall_count);
        end
        @(negedge m_clock);
        n_checks++;
        if (scan_done !== 1'b0 || scan_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b busy=%b, required 0 0", scan_done, scan_busy);
        end
    endtask

    task automatic test_dup;
        int cyc;
        bit seen;
        load_mem(10'h001);
        mem[2] = 10'h1FF;
        mem[7] = 10'h1FF;
        mem[5] = 10'h000;
        run_scan(cyc, seen);
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL dup_done: scan_done seen=%b, required 1", seen);
        end
        n_checks++;
        if (start_pos !== 10'd2 || start_found !== 1'b1 || err_dup !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_start: pos=%0d found=%b dup=%b, required 2 1 1",
                     start_pos, start_found, err_dup);
        end
        n_checks++;
        if (goal_pos !== 10'd5 || goal_found !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_goal: pos=%0d found=%b, required 5 1", goal_pos, goal_found);
        end
    endtask

    task automatic test_walls;
        int cyc;
        bit seen;
        load_mem(10'h100);
        mem[0]  = 10'h200;
        mem[1]  = 10'h200;
        mem[15] = 10'h200;
        run_scan(cyc, seen);
        n_checks++;
        if (!seen || wall_count !== 11'd3) begin
            n_fail++;
            $display("FAIL walls_count: seen=%b wc=%0d, required 1 3", seen, wall_count);
        end
        n_checks++;
        if (start_found !== 1'b0 || goal_found !== 1'b0 || err_dup !== 1'b0) begin
            n_fail++;
            $display("FAIL walls_flags: sf=%b gf=%b dup=%b, required 0 0 0",
                     start_found, goal_found, err_dup);
        end
        repeat (5) @(negedge m_clock);
        n_checks++;
        if (wall_count !== 11'd3 || scan_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL walls_hold: wc=%0d busy=%b, required 3 0", wall_count, scan_busy);
        end
    endtask

    task automatic test_abort;
        int cyc;
        bit seen;
        int dones;
        bit hit;
        load_mem(10'h001);
        mem[3] = 10'h1FF;
        mem[9] = 10'h000;
        @(negedge m_clock);
        scan_req = 1'b1;
        @(posedge m_clock);
        #1 scan_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge m_clock);
            if (mem_rd && mem_addr == 10'd6) begin
                hit = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!hit || start_found !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach: reached=%b start_found=%b, required 1 1", hit, start_found);
        end
        scan_abort = 1'b1;
        @(posedge m_clock);
        #1 scan_abort = 1'b0;
        @(negedge m_clock);
        n_checks++;
        if (scan_busy !== 1'b0 || blk_in_do !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b in_do=%b rd=%b, required 0 0 0",
                     scan_busy, blk_in_do, mem_rd);
        end
        n_checks++;
        if (start_found !== 1'b0 || goal_found !== 1'b0 || err_dup !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_flags: sf=%b gf=%b dup=%b, required 0 0 0",
                     start_found, goal_found, err_dup);
        end
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge m_clock);
            if (scan_done) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: scan_done pulses=%0d, required 0", dones);
        end
        // Abort and request together in IDLE: abort wins
        scan_req   = 1'b1;
        scan_abort = 1'b1;
        @(posedge m_clock);
        #1;
        scan_req   = 1'b0;
        scan_abort = 1'b0;
        @(negedge m_clock);
        n_checks++;
        if (scan_busy !== 1'b0 || mem_rd !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_req_same: busy=%b rd=%b, required 0 0", scan_busy, mem_rd);
        end
        run_scan(cyc, seen);
        n_checks++;
        if (!seen || cyc != 18 || start_pos !== 10'd3 || goal_pos !== 10'd9 ||
            start_found !== 1'b1 || goal_found !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_rescan: seen=%b cyc=%0d sp=%0d gp=%0d sf=%b gf=%b, required 1 18 3 9 1 1",
                     seen, cyc, start_pos, goal_pos, start_found, goal_found);
        end
    endtask

    task automatic test_req_held;
        int dones;
        bit dropped;
        @(negedge m_clock);
        scan_req = 1'b1;
        dones    = 0;
        dropped  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge m_clock);
            if (scan_done) begin
                dones++;
                scan_req = 1'b0;
                dropped  = 1'b1;
            end
        end
        scan_req = 1'b0;
        n_checks++;
        if (dones != 1 || !dropped) begin
            n_fail++;
            $display("FAIL req_held_single: scan_done pulses=%0d, required 1", dones);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        bit hit;
        @(negedge m_clock);
        scan_req = 1'b1;
        @(posedge m_clock);
        #1 scan_req = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge m_clock);
            if (mem_rd && mem_addr == 10'd4) begin
                hit = 1'b1;
                break;
            end
        end
        p_reset = 1'b0;
        #2;
        n_checks++;
        if (!hit || {mem_rd, mem_addr, blk_in_do, scan_busy, scan_done, start_pos, goal_pos,
                     start_found, goal_found, err_dup, wall_count} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: reached=%b busy=%b rd=%b addr=%0d sf=%b, required 1 0 0 0 0",
                     hit, scan_busy, mem_rd, mem_addr, start_found);
        end
        @(negedge m_clock);
        p_reset = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge m_clock);
            if (scan_done || scan_busy) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: busy/done cycles=%0d, required 0", dones);
        end
    endtask

    initial begin
        p_reset    = 1'b0;
        scan_req   = 1'b0;
        scan_abort = 1'b0;
        load_mem(10'h001);
        test_reset();
        test_basic();
        test_dup();
        test_walls();
        test_abort();
        test_req_held();
        test_reset_mid();
        repeat (2) @(negedge m_clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
